mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Two-requester arbiter and sequencer for the MCU memory bus. Master 0 (fetch)
//   and master 1 (load/store) share one slave bus to BRAM, SRAM, flash and
//   peripherals. Round-robin grant; decodes the address region and drives a one-hot
//   target select. Waits for target ready, with a timeout. Returns data, ack and err.
// PARAMETERS
//   ADDR_W   32  address width (region taken from addr[31:16])
//   DATA_W   32  data width
//   TIMEOUT  15  max ACCESS cycles without s_ready before error response (>=1)
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   m0_req     in   1       master 0 request; held with addr/we/wdata until ack
//   m0_we      in   1       1 = write
//   m0_addr    in   ADDR_W  byte address
//   m0_wdata   in   DATA_W  write data
//   m0_ack     out  1       one-cycle completion pulse
//   m0_err     out  1       qualifies m0_ack: invalid region or timeout
//   m0_rdata   out  DATA_W  read data, valid with m0_ack
//   m1_*       (same seven signals for master 1)
//   s_valid    out  1       slave access in progress
//   s_sel      out  4       one-hot {periph,flash,sram,bram}
//   s_we       out  1       latched write enable
//   s_addr     out  ADDR_W  latched address
//   s_wdata    out  DATA_W  latched write data
//   s_ready    in   1       target completes access this cycle
//   s_rdata    in   DATA_W  target read data, valid with s_ready
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE; all outputs 0; cnt=0; last_grant=1,
//     so m0 wins the first contention.
//   - FSM states: IDLE, ACCESS, RESP. All outputs are registered or state-decoded.
//   - IDLE: if no req, stay. Only one req: grant it. Both: grant !last_grant.
//     Latch we/addr/wdata of the winner and decode addr[31:16]:
//     0x0000 bram, 0x0001 sram, 0x0002 flash, 0x0003 periph, else invalid.
//     Valid -> ACCESS with cnt=0. Invalid -> RESP with err=1; s_valid never rises.
//   - ACCESS: s_valid=1 and s_sel, s_we, s_addr, s_wdata are held stable.
//     On s_ready: capture s_rdata (0 on writes) and go to RESP, err=0.
//     Else cnt++. If cnt reaches TIMEOUT-1 without s_ready: go to RESP, err=1,
//     rdata=0, s_valid drops.
//     If s_ready arrives in the last allowed cycle, ready wins (no error).
//   - RESP: assert mX_ack (and mX_err) for one cycle on the granted master only.
//     mX_rdata is valid this cycle; last_grant=granted; next state IDLE.
//   - Latency from req sampled in IDLE:
//     invalid region -> ack 1 cycle later.
//     zero-wait target -> ack 2 cycles later.
//     k wait cycles -> 2+k cycles.
//   - No pipelining: one outstanding access. The non-granted req waits, no ack.
//     A master drops or changes req after its ack. The RESP->IDLE cycle always
//     resamples both reqs, so back-to-back requests alternate under contention.
//   - s_ready outside ACCESS is ignored. s_rdata is sampled only with s_ready.
//   - A req that deasserts before ack is a protocol violation. The latched
//     access still completes.
//   - Reset during ACCESS: s_valid, s_sel and acks clear asynchronously and the
//     transaction is discarded. A req still held after release restarts from IDLE.
//   - cnt width is $clog2(TIMEOUT+1). cnt saturates; it never wraps.
// STRUCTURE
//   - mem_map_pkg: region base constants (16'h0000..16'h0003), region enum
//     {BRAM,SRAM,FLASH,PERIPH,INVALID}, FSM state enum, SEL_* one-hot constants.
//   - Sub-module mem_region_decode: addr[31:16] -> s_sel one-hot + invalid flag.
//     It is pure combinational. Everything else lives in mem_bus_arbiter.
// TESTING
//   1. m0 read 0x0000_0010, s_ready same cycle as s_valid, s_rdata=0xDEADBEEF
//      -> s_sel=4'b0001; m0_ack 2 cycles after req; m0_rdata=0xDEADBEEF; m0_err=0.
//   2. After reset, m0 (0x0001_0000) and m1 (0x0003_0004) req in the same cycle
//      -> m0 served first (s_sel=0010), then m1 (s_sel=1000).
//      A third simultaneous pair -> m0 again.
//   3. m1 write to 0x0004_0000 -> m1_ack=1 and m1_err=1 one cycle after req;
//      s_valid stays 0 throughout.
//   4. m0 read 0x0002_0000, s_ready held 0, TIMEOUT=15 -> s_valid high exactly
//      15 cycles; then m0_ack=1, m0_err=1, m0_rdata=0.
//      Repeat with s_ready only in the 15th cycle -> m0_err=0, data returned.
//   5. rst pulsed mid-ACCESS with no clock edge -> s_valid, s_sel and acks go 0
//      immediately. After release, held m1 req completes normally, m0 has priority.
//   6. Random back-to-back traffic, both masters, random wait states (0-20)
//      -> exactly one ack per req; acks never coincide; s_sel always one-hot or 0.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Memory map of the MCU bus: region bases, region enum, target select
// encodings and the arbiter FSM state constants.
package mem_map_pkg;

    // Upper 16 address bits selecting each target region
    localparam logic [15:0] REGION_BRAM_BASE   = 16'h0000;
    localparam logic [15:0] REGION_SRAM_BASE   = 16'h0001;
    localparam logic [15:0] REGION_FLASH_BASE  = 16'h0002;
    localparam logic [15:0] REGION_PERIPH_BASE = 16'h0003;

    typedef enum logic [2:0] {
        REG_BRAM,
        REG_SRAM,
        REG_FLASH,
        REG_PERIPH,
        REG_INVALID
    } region_e;

    // One-hot target selects, bit order {periph,flash,sram,bram}
    localparam logic [3:0] SEL_NONE   = 4'b0000;
    localparam logic [3:0] SEL_BRAM   = 4'b0001;
    localparam logic [3:0] SEL_SRAM   = 4'b0010;
    localparam logic [3:0] SEL_FLASH  = 4'b0100;
    localparam logic [3:0] SEL_PERIPH = 4'b1000;

    // Arbiter FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    function automatic region_e region_of(input logic [15:0] hi);
        region_e r;
        case (hi)
            REGION_BRAM_BASE:   r = REG_BRAM;
            REGION_SRAM_BASE:   r = REG_SRAM;
            REGION_FLASH_BASE:  r = REG_FLASH;
            REGION_PERIPH_BASE: r = REG_PERIPH;
            default:            r = REG_INVALID;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational region decoder: upper address half -> one-hot target select
// plus an invalid flag for unmapped regions.
module mem_region_decode
    import mem_map_pkg::*;
(
    input  logic [15:0] region_hi,
    output logic [3:0]  sel,
    output logic        invalid
);

    region_e region;

    // Map the region to its target select; unmapped regions select nothing
    always_comb begin
        region  = region_of(region_hi);
        sel     = SEL_NONE;
        invalid = 1'b0;
        case (region)
            REG_BRAM:   sel = SEL_BRAM;
            REG_SRAM:   sel = SEL_SRAM;
            REG_FLASH:  sel = SEL_FLASH;
            REG_PERIPH: sel = SEL_PERIPH;
            default:    invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the MCU memory bus.
// One access outstanding at a time: IDLE grants and latches, ACCESS waits for
// target ready (bounded by TIMEOUT), RESP pulses ack/err to the winner.
module mem_bus_arbiter
    import mem_map_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              s_valid,
    output logic [3:0]        s_sel,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                grant_q, grant_d;          // 0 = m0, 1 = m1
    logic                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Winner of the current IDLE cycle: a lone requester wins outright,
    // under contention the master not served last time wins.
    logic                pick_m1;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic [3:0]          dec_sel;
    logic                dec_invalid;

    assign pick_m1   = m1_req & (~m0_req | ~last_grant_q);
    assign win_we    = pick_m1 ? m1_we    : m0_we;
    assign win_addr  = pick_m1 ? m1_addr  : m0_addr;
    assign win_wdata = pick_m1 ? m1_wdata : m0_wdata;

    mem_region_decode u_decode (
        .region_hi (win_addr[ADDR_W-1 -: 16]),
        .sel       (dec_sel),
        .invalid   (dec_invalid)
    );

    // Next-state and datapath: grant/latch in IDLE, wait or time out in
    // ACCESS, record the served master in RESP
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d = pick_m1;
                    we_d    = win_we;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    sel_d   = dec_sel;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = dec_invalid;
                    state_d = dec_invalid ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Ready takes precedence over the timeout in the last cycle
                if (s_ready) begin
                    rdata_d = we_q ? '0 : s_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset leaves m1 as last served so m0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            sel_q        <= SEL_NONE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Outputs are state-decoded so reset clears them without a clock edge
    logic in_resp;
    assign in_resp  = (state_q == ST_RESP);
    assign s_valid  = (state_q == ST_ACCESS);
    assign s_sel    = s_valid ? sel_q : SEL_NONE;
    assign s_we     = we_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;

    assign m0_ack   = in_resp & ~grant_q;
    assign m1_ack   = in_resp &  grant_q;
    assign m0_err   = m0_ack & err_q;
    assign m1_err   = m1_ack & err_q;
    assign m0_rdata = m0_ack ? rdata_q : '0;
    assign m1_rdata = m1_ack ? rdata_q : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random
// two-master traffic against a latency/round-robin transaction model.
module tb_mem_bus_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic        pend;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          issued;
        int          acked;
    } mst_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_we, s_ready;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata)
    );

    task automatic zero_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        s_ready = 0; s_rdata = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        zero_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Answers every ACCESS cycle with immediate ready until some ack shows
    task automatic run_until_ack(input logic [31:0] data, output logic [1:0] acks,
                                 output logic [3:0] sel_seen, output logic [31:0] rd,
                                 output logic err);
        acks = '0; sel_seen = '0; rd = '0; err = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                acks = {m1_ack, m0_ack};
                rd   = m1_ack ? m1_rdata : m0_rdata;
                err  = m1_ack ? m1_err : m0_err;
                break;
            end
            if (s_valid) begin
                sel_seen = s_sel; s_ready = 1'b1; s_rdata = data;
            end else begin
                s_ready = 1'b0;
            end
        end
        s_ready = 1'b0;
    endtask

    task automatic test_reset();
        zero_inputs();
        rst = 1'b1;
        #1;
        checks++; if ({m0_ack, m0_err, m1_ack, m1_err, s_valid, s_we} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {m0_ack, m0_err, m1_ack, m1_err, s_valid, s_we}); end
        checks++; if (s_sel !== 4'b0) begin failures++; $display("FAIL reset_s_sel got=%b exp=0000", s_sel); end
        checks++; if (s_addr !== 32'h0) begin failures++; $display("FAIL reset_s_addr got=%h exp=0", s_addr); end
        checks++; if (s_wdata !== 32'h0) begin failures++; $display("FAIL reset_s_wdata got=%h exp=0", s_wdata); end
        checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", m0_rdata, m1_rdata); end
        apply_reset();
        checks++; if ({m0_ack, m1_ack, s_valid} !== 3'b0) begin failures++; $display("FAIL reset_idle got=%b exp=000", {m0_ack, m1_ack, s_valid}); end
    endtask

    task automatic test_read_zero_wait();
        apply_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010;
        @(posedge clk); @(negedge clk);
        checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL zw_s_valid got=%b exp=1", s_valid); end
        checks++; if (s_sel !== 4'b0001) begin failures++; $display("FAIL zw_s_sel got=%b exp=0001", s_sel); end
        checks++; if (s_addr !== 32'h0000_0010) begin failures++; $display("FAIL zw_s_addr got=%h exp=00000010", s_addr); end
        checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL zw_early_ack got=%b exp=0", m0_ack); end
        s_ready = 1; s_rdata = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        checks++; if ({m0_ack, m0_err, m1_ack} !== 3'b100) begin failures++; $display("FAIL zw_ack got=%b exp=100", {m0_ack, m0_err, m1_ack}); end
        checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL zw_rdata got=%h exp=deadbeef", m0_rdata); end
        m0_req = 0; s_ready = 0; s_rdata = '0;
        @(posedge clk); @(negedge clk);
        checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL zw_ack_pulse got=%b exp=0", m0_ack); end
    endtask

    task automatic test_contention();
        logic [1:0] acks; logic [3:0] sel; logic [31:0] rd; logic err;
        apply_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h0001_0000;
        m1_req = 1; m1_we = 0; m1_addr = 32'h0003_0004;
        run_until_ack(32'h1111_0000, acks, sel, rd, err);
        checks++; if (acks !== 2'b01) begin failures++; $display("FAIL cont_first got=%b exp=01", acks); end
        checks++; if (sel !== 4'b0010) begin failures++; $display("FAIL cont_first_sel got=%b exp=0010", sel); end
        checks++; if (rd !== 32'h1111_0000) begin failures++; $display("FAIL cont_first_rd got=%h exp=11110000", rd); end
        m0_req = 0;
        run_until_ack(32'h2222_0000, acks, sel, rd, err);
        checks++; if (acks !== 2'b10) begin failures++; $display("FAIL cont_second got=%b exp=10", acks); end
        checks++; if (sel !== 4'b1000) begin failures++; $display("FAIL cont_second_sel got=%b exp=1000", sel); end
        m0_req = 1; m0_addr = 32'h0001_0000;
        run_until_ack(32'h3333_0000, acks, sel, rd, err);
        checks++; if (acks !== 2'b01) begin failures++; $display("FAIL cont_third got=%b exp=01", acks); end
        checks++; if (sel !== 4'b0010) begin failures++; $display("FAIL cont_third_sel got=%b exp=0010", sel); end
        m0_req = 0;
        run_until_ack(32'h4444_0000, acks, sel, rd, err);
        checks++; if (acks !== 2'b10) begin failures++; $display("FAIL cont_fourth got=%b exp=10", acks); end
        m1_req = 0;
    endtask

    task automatic test_invalid();
        repeat (2) @(negedge clk);
        m1_req = 1; m1_we = 1; m1_addr = 32'h0004_0000; m1_wdata = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        checks++; if ({m1_ack, m1_err, m0_ack} !== 3'b110) begin failures++; $display("FAIL inv_ack got=%b exp=110", {m1_ack, m1_err, m0_ack}); end
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL inv_s_valid got=%b exp=0", s_valid); end
        checks++; if (m1_rdata !== 32'h0) begin failures++; $display("FAIL inv_rdata got=%h exp=0", m1_rdata); end
        m1_req = 0;
        @(posedge clk); @(negedge clk);
        checks++; if ({m1_ack, s_valid} !== 2'b00) begin failures++; $display("FAIL inv_after got=%b exp=00", {m1_ack, s_valid}); end
    endtask

    task automatic test_timeout();
        int vcnt; logic got; logic exp_err; logic [31:0] exp_rd;
        for (int run = 0; run < 2; run++) begin
            repeat (2) @(negedge clk);
            m0_req = 1; m0_we = 0; m0_addr = 32'h0002_0000; s_ready = 0;
            vcnt = 0; got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(posedge clk); @(negedge clk);
                if (m0_ack) got = 1;
                else begin
                    if (s_valid) vcnt++;
                    s_ready = (run == 1) && s_valid && (vcnt == TIMEOUT);
                    s_rdata = s_ready ? 32'hC0FF_EE01 : 32'h0;
                end
            end
            exp_err = (run == 0);
            exp_rd  = (run == 0) ? 32'h0 : 32'hC0FF_EE01;
            checks++; if (got !== 1'b1) begin failures++; $display("FAIL to_ack run=%0d got=%b exp=1", run, got); end
            checks++; if (vcnt != TIMEOUT) begin failures++; $display("FAIL to_valid_cycles run=%0d got=%0d exp=%0d", run, vcnt, TIMEOUT); end
            checks++; if (m0_err !== exp_err) begin failures++; $display("FAIL to_err run=%0d got=%b exp=%b", run, m0_err, exp_err); end
            checks++; if (m0_rdata !== exp_rd) begin failures++; $display("FAIL to_rdata run=%0d got=%h exp=%h", run, m0_rdata, exp_rd); end
            m0_req = 0; s_ready = 0; s_rdata = '0;
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] acks; logic [3:0] sel; logic [31:0] rd; logic err;
        repeat (2) @(negedge clk);
        m1_req = 1; m1_we = 0; m1_addr = 32'h0000_0020; s_ready = 0;
        @(posedge clk); @(negedge clk);
        checks++; if ({s_valid, s_sel} !== 5'b10001) begin failures++; $display("FAIL rm_pre got=%b exp=10001", {s_valid, s_sel}); end
        rst = 1;
        #1;
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL rm_s_valid got=%b exp=0", s_valid); end
        checks++; if (s_sel !== 4'b0) begin failures++; $display("FAIL rm_s_sel got=%b exp=0000", s_sel); end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL rm_acks got=%b exp=00", {m0_ack, m1_ack}); end
        #1;
        rst = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h0001_0008;
        run_until_ack(32'hA5A5_0001, acks, sel, rd, err);
        checks++; if (acks !== 2'b01) begin failures++; $display("FAIL rm_m0_first got=%b exp=01", acks); end
        m0_req = 0;
        run_until_ack(32'hA5A5_0002, acks, sel, rd, err);
        checks++; if (acks !== 2'b10) begin failures++; $display("FAIL rm_m1 got=%b exp=10", acks); end
        checks++; if ({sel, err} !== 5'b00010) begin failures++; $display("FAIL rm_m1_sel_err got=%b exp=00010", {sel, err}); end
        checks++; if (rd !== 32'hA5A5_0002) begin failures++; $display("FAIL rm_m1_rd got=%h exp=a5a50002", rd); end
        m1_req = 0;
    endtask

    task automatic test_random();
        mst_t        mst [2];
        int          e, next_sample, ack_edge, resp_wait, resp_cnt, k;
        logic        busy, last, exp_m, exp_err, exp_inv, exp_we, exp_sv;
        logic [31:0] exp_rdata, resp_data, exp_addr, exp_wdata, r32;
        logic [3:0]  exp_sel;
        logic [15:0] hi;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            mst[i].pend = 0; mst[i].we = 0; mst[i].addr = '0; mst[i].wdata = '0;
            mst[i].issued = 0; mst[i].acked = 0;
        end
        e = 0; next_sample = 1; busy = 0; last = 1; ack_edge = 0; exp_inv = 0;
        exp_m = 0; exp_err = 0; exp_we = 0; exp_rdata = '0; exp_addr = '0; exp_wdata = '0;
        exp_sel = '0; resp_wait = 0; resp_cnt = 0; resp_data = '0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(posedge clk);
            e++;
            // Model: a new grant whenever idle and something is pending
            if (!busy && e >= next_sample && (mst[0].pend || mst[1].pend)) begin
                exp_m     = (mst[0].pend && mst[1].pend) ? ~last : mst[1].pend;
                last      = exp_m;
                exp_addr  = mst[exp_m].addr;
                exp_we    = mst[exp_m].we;
                exp_wdata = mst[exp_m].wdata;
                hi        = exp_addr[31:16];
                exp_inv   = hi > 16'd3;
                exp_sel   = exp_inv ? 4'b0 : (4'b0001 << hi[1:0]);
                resp_wait = $urandom_range(0, 20);
                resp_cnt  = 0;
                resp_data = $urandom();
                busy      = 1;
                if (exp_inv) begin
                    ack_edge = e; exp_err = 1; exp_rdata = '0;
                end else if (resp_wait <= TIMEOUT - 1) begin
                    ack_edge = e + 1 + resp_wait; exp_err = 0; exp_rdata = exp_we ? 32'h0 : resp_data;
                end else begin
                    ack_edge = e + TIMEOUT; exp_err = 1; exp_rdata = '0;
                end
            end
            @(negedge clk);
            exp_sv = busy && !exp_inv && (e < ack_edge);
            checks++; if (s_valid !== exp_sv) begin failures++; $display("FAIL rnd_s_valid e=%0d got=%b exp=%b", e, s_valid, exp_sv); end
            if (exp_sv) begin
                checks++; if ({s_sel, s_we, s_addr, s_wdata} !== {exp_sel, exp_we, exp_addr, exp_wdata}) begin failures++; $display("FAIL rnd_s_bus e=%0d got=%b/%b/%h/%h exp=%b/%b/%h/%h", e, s_sel, s_we, s_addr, s_wdata, exp_sel, exp_we, exp_addr, exp_wdata); end
            end
            checks++; if ($countones(s_sel) > 1) begin failures++; $display("FAIL rnd_sel_onehot e=%0d got=%b exp=onehot_or_0", e, s_sel); end
            if (busy && e == ack_edge) begin
                checks++; if ({m1_ack, m0_ack} !== (exp_m ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rnd_ack e=%0d got=%b exp_master=%0d", e, {m1_ack, m0_ack}, exp_m); end
                checks++; if ((exp_m ? m1_err : m0_err) !== exp_err) begin failures++; $display("FAIL rnd_err e=%0d got=%b exp=%b", e, exp_m ? m1_err : m0_err, exp_err); end
                checks++; if ((exp_m ? m1_rdata : m0_rdata) !== exp_rdata) begin failures++; $display("FAIL rnd_rdata e=%0d got=%h exp=%h", e, exp_m ? m1_rdata : m0_rdata, exp_rdata); end
                busy = 0;
                next_sample = e + 2;
                mst[exp_m].pend = 0;
                mst[exp_m].acked++;
            end else begin
                checks++; if ({m1_ack, m0_ack} !== 2'b00) begin failures++; $display("FAIL rnd_spurious_ack e=%0d got=%b exp=00", e, {m1_ack, m0_ack}); end
            end
            // Target: ready after the chosen number of wait cycles; noise elsewhere
            if (s_valid) begin
                s_ready = (resp_cnt == resp_wait);
                s_rdata = s_ready ? resp_data : $urandom();
                resp_cnt++;
            end else begin
                s_ready = 1'($urandom_range(0, 1));
                s_rdata = $urandom();
            end
            // Masters: issue new requests while traffic is enabled
            for (int i = 0; i < 2; i++) begin
                if (!mst[i].pend && cyc < 700 && $urandom_range(0, 9) < 4) begin
                    r32 = $urandom();
                    k   = $urandom_range(0, 4);
                    hi  = (k < 4) ? 16'(k) : 16'(32'h4 + $urandom_range(0, 32'hFFF0));
                    mst[i].pend  = 1;
                    mst[i].we    = r32[31];
                    mst[i].addr  = {hi, r32[15:0]};
                    mst[i].wdata = $urandom();
                    mst[i].issued++;
                end
            end
            m0_req = mst[0].pend; m0_we = mst[0].we; m0_addr = mst[0].addr; m0_wdata = mst[0].wdata;
            m1_req = mst[1].pend; m1_we = mst[1].we; m1_addr = mst[1].addr; m1_wdata = mst[1].wdata;
            if (cyc >= 700 && !busy && !mst[0].pend && !mst[1].pend) break;
        end
        checks++; if (busy || mst[0].pend || mst[1].pend) begin failures++; $display("FAIL rnd_drain got=busy%b/pend%b%b exp=idle", busy, mst[0].pend, mst[1].pend); end
        checks++; if (mst[0].acked != mst[0].issued) begin failures++; $display("FAIL rnd_m0_count got=%0d exp=%0d", mst[0].acked, mst[0].issued); end
        checks++; if (mst[1].acked != mst[1].issued) begin failures++; $display("FAIL rnd_m1_count got=%0d exp=%0d", mst[1].acked, mst[1].issued); end
        zero_inputs();
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_contention();
        test_invalid();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
